// File: rtl/otter_mem_pkg.sv
// rtl/otter_mem_pkg.sv - shared types and encodings for the OTTER memory arbiter
//   state_t : arbiter FSM states (IDLE, ISSUE, RESP)
//   owner_t : which requester owns the in-flight access (CPU or DMA)
//   SZ_*    : access size encodings carried on cpu_size/dma_size/mem_size
package otter_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/otter_arb_pick.sv
// rtl/otter_arb_pick.sv - combinational two-way arbitration policy
//   cpu_req, dma_req : requests sampled this cycle
//   last_gnt         : requester granted most recently (round-robin only)
//   gnt[1:0]         : one-hot winner, bit 0 = CPU, bit 1 = DMA, 0 = none
//   Macro OTTER_MEM_ARB_RR_EN selects round-robin; otherwise fixed CPU>DMA.
module otter_arb_pick
    import otter_mem_pkg::*;
(
    input  logic       cpu_req,
    input  logic       dma_req,
    input  owner_t     last_gnt,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
`ifdef OTTER_MEM_ARB_RR_EN
        // On contention the requester that did not win last time goes first.
        if (cpu_req && dma_req) begin
            gnt = (last_gnt == OWN_DMA) ? 2'b01 : 2'b10;
        end else if (cpu_req) begin
            gnt = 2'b01;
        end else if (dma_req) begin
            gnt = 2'b10;
        end
`else
        if (cpu_req) begin
            gnt = 2'b01;
        end else if (dma_req) begin
            gnt = 2'b10;
        end
`endif
    end

`ifndef OTTER_MEM_ARB_RR_EN
    // Fixed priority ignores the pointer; the port stays for a uniform interface.
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt;
`endif

endmodule

// File: rtl/otter_mem_arbiter.sv
// rtl/otter_mem_arbiter.sv - CPU/DMA arbiter in front of a single-port memory
//   CLK, RST (sync, active-high)
//   cpu_*    : CPU request port (req/we/addr/wdata/size in, gnt/rvalid out)
//   dma_*    : DMA request port, same shape as the CPU port
//   rdata    : read data for the owner, qualified by its rvalid, else 0
//   mem_*    : command to memory during ISSUE; mem_rdata returns next cycle
//   busy     : FSM not in IDLE
//   Macro OTTER_MEM_ARB_RR_EN enables round-robin contention resolution.
module otter_mem_arbiter
    import otter_mem_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [1:0]  cpu_size,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic [1:0]  dma_size,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [31:0] rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_size,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    state_t      state, state_nx;
    owner_t      owner;
    logic        cap_we;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [1:0]  cap_size;

    logic        arb_en;
    logic [1:0]  pick_gnt;
    logic        win_cpu;
    logic        win_dma;
    owner_t      pick_last;

    otter_arb_pick u_pick (
        .cpu_req  (cpu_req),
        .dma_req  (dma_req),
        .last_gnt (pick_last),
        .gnt      (pick_gnt)
    );

`ifdef OTTER_MEM_ARB_RR_EN
    owner_t last_q;

    // Resets to DMA so the CPU wins the first contention.
    always_ff @(posedge CLK) begin
        if (RST) begin
            last_q <= OWN_DMA;
        end else if (win_cpu) begin
            last_q <= OWN_CPU;
        end else if (win_dma) begin
            last_q <= OWN_DMA;
        end
    end

    assign pick_last = last_q;
`else
    assign pick_last = OWN_DMA;
`endif

    // Grants exist only in arbitration states and never while reset is high.
    assign arb_en  = !RST && ((state == ST_IDLE) || (state == ST_RESP));
    assign win_cpu = arb_en && pick_gnt[0];
    assign win_dma = arb_en && pick_gnt[1];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            owner     <= OWN_CPU;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_size  <= '0;
        end else begin
            state <= state_nx;
            if (win_cpu) begin
                owner     <= OWN_CPU;
                cap_we    <= cpu_we;
                cap_addr  <= cpu_addr;
                cap_wdata <= cpu_wdata;
                cap_size  <= cpu_size;
            end else if (win_dma) begin
                owner     <= OWN_DMA;
                cap_we    <= dma_we;
                cap_addr  <= dma_addr;
                cap_wdata <= dma_wdata;
                cap_size  <= dma_size;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        cpu_gnt    = win_cpu;
        dma_gnt    = win_dma;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_size   = '0;
        cpu_rvalid = 1'b0;
        dma_rvalid = 1'b0;
        rdata      = '0;
        busy       = (state != ST_IDLE);

        case (state)
            ST_IDLE: begin
                state_nx = (win_cpu || win_dma) ? ST_ISSUE : ST_IDLE;
            end
            ST_ISSUE: begin
                // Driven even when RST is high so an in-flight write still lands.
                mem_en    = 1'b1;
                mem_we    = cap_we;
                mem_addr  = cap_addr;
                mem_wdata = cap_wdata;
                mem_size  = cap_size;
                state_nx  = ST_RESP;
            end
            ST_RESP: begin
                if (!cap_we) begin
                    cpu_rvalid = (owner == OWN_CPU);
                    dma_rvalid = (owner == OWN_DMA);
                    rdata      = mem_rdata;
                end
                state_nx = (win_cpu || win_dma) ? ST_ISSUE : ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// tb/tb_otter_mem_arbiter.sv - self-checking bench for otter_mem_arbiter
module tb_otter_mem_arbiter;
    import otter_mem_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;
    logic [1:0]  cpu_size, dma_size;
    logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic        mem_en, mem_we, busy;
    logic [1:0]  mem_size;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        v;
        logic        who;    // 1 = DMA
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
    } acc_t;

    always #5 CLK = ~CLK;

    otter_mem_arbiter dut (
        .CLK(CLK), .RST(RST),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_size(cpu_size),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_size(dma_size),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
        .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_size(mem_size),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_size = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0; dma_size = 0;
        mem_rdata = 0;
    endtask

    task automatic pulse_reset();
        clr_inputs();
        RST = 1;
        next_cycle();
        RST = 0;
    endtask

    task automatic test_reset();
        clr_inputs();
        RST = 1;
        cpu_req = 1;
        @(negedge CLK);
        checks++;
        if (cpu_gnt !== 1'b0 || dma_gnt !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_gnt: cpu_gnt=%b dma_gnt=%b expected 0 0", cpu_gnt, dma_gnt);
        end
        next_cycle();
        cpu_req = 0;
        next_cycle();
        @(negedge CLK);
        checks++;
        if ({cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, mem_en, mem_we, busy} !== 7'b0 ||
            rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_size !== 2'b0) begin
            failures++;
            $display("FAIL reset_outputs: busy=%b mem_en=%b rdata=%h mem_addr=%h expected all 0",
                     busy, mem_en, rdata, mem_addr);
        end
        RST = 0;
        next_cycle();
    endtask

    task automatic test_cpu_read();
        clr_inputs();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100; cpu_size = SZ_WORD;
        @(negedge CLK);
        checks++;
        if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL cpu_read_gnt: cpu_gnt=%b dma_gnt=%b busy=%b expected 1 0 0", cpu_gnt, dma_gnt, busy);
        end
        next_cycle();
        cpu_req = 0;
        @(negedge CLK);
        checks++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100 || mem_size !== SZ_WORD ||
            busy !== 1'b1 || cpu_gnt !== 1'b0) begin
            failures++;
            $display("FAIL cpu_read_issue: mem_en=%b mem_we=%b mem_addr=%h busy=%b expected 1 0 00000100 1",
                     mem_en, mem_we, mem_addr, busy);
        end
        next_cycle();
        mem_rdata = 32'hDEADBEEF;
        @(negedge CLK);
        checks++;
        if (cpu_rvalid !== 1'b1 || dma_rvalid !== 1'b0 || rdata !== 32'hDEADBEEF || mem_en !== 1'b0) begin
            failures++;
            $display("FAIL cpu_read_resp: cpu_rvalid=%b dma_rvalid=%b rdata=%h expected 1 0 deadbeef",
                     cpu_rvalid, dma_rvalid, rdata);
        end
        next_cycle();
        @(negedge CLK);
        checks++;
        if (cpu_rvalid !== 1'b0 || rdata !== 32'h0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL cpu_read_after: cpu_rvalid=%b rdata=%h busy=%b expected 0 0 0", cpu_rvalid, rdata, busy);
        end
        next_cycle();
    endtask

    task automatic test_dma_write();
        clr_inputs();
        dma_req = 1; dma_we = 1; dma_addr = 32'h200; dma_wdata = 32'h12345678; dma_size = SZ_WORD;
        @(negedge CLK);
        checks++;
        if (dma_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin
            failures++;
            $display("FAIL dma_write_gnt: dma_gnt=%b cpu_gnt=%b expected 1 0", dma_gnt, cpu_gnt);
        end
        next_cycle();
        dma_req = 0;
        @(negedge CLK);
        checks++;
        if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h200 ||
            mem_wdata !== 32'h12345678 || mem_size !== 2'b10) begin
            failures++;
            $display("FAIL dma_write_issue: mem_en=%b mem_we=%b addr=%h wdata=%h size=%b expected 1 1 200 12345678 10",
                     mem_en, mem_we, mem_addr, mem_wdata, mem_size);
        end
        next_cycle();
        mem_rdata = 32'hCAFEF00D;
        @(negedge CLK);
        checks++;
        if (dma_rvalid !== 1'b0 || cpu_rvalid !== 1'b0 || rdata !== 32'h0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL dma_write_resp: dma_rvalid=%b cpu_rvalid=%b rdata=%h busy=%b expected 0 0 0 1",
                     dma_rvalid, cpu_rvalid, rdata, busy);
        end
        next_cycle();
        next_cycle();
    endtask

    task automatic test_contention();
        logic [3:0] seq;
        logic [3:0] exp_seq;
        int         n;
        pulse_reset();
        cpu_req = 1; cpu_addr = 32'h10; dma_req = 1; dma_addr = 32'h20;
        seq = 0;
        n = 0;
`ifdef OTTER_MEM_ARB_RR_EN
        exp_seq = 4'b1010;    // bit i = 1 when access i went to DMA: C,D,C,D
`else
        exp_seq = 4'b0000;
`endif
        for (int c = 0; c < 20 && n < 4; c++) begin
            @(negedge CLK);
            if (cpu_gnt && dma_gnt) begin
                checks++;
                failures++;
                $display("FAIL contention_onehot: cpu_gnt=1 dma_gnt=1 expected at most one");
            end
            if (cpu_gnt || dma_gnt) begin
                seq[n] = dma_gnt;
                n++;
            end
            next_cycle();
        end
        checks++;
        if (n !== 4 || seq !== exp_seq) begin
            failures++;
            $display("FAIL contention_order: grants=%0d pattern=%b expected 4 grants pattern=%b", n, seq, exp_seq);
        end
        clr_inputs();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_reset_in_issue();
        pulse_reset();
        cpu_req = 1; cpu_addr = 32'h100;
        @(negedge CLK);
        next_cycle();
        cpu_req = 0;
        RST = 1;
        dma_req = 1;
        @(negedge CLK);
        checks++;
        if (dma_gnt !== 1'b0 || cpu_gnt !== 1'b0) begin
            failures++;
            $display("FAIL rst_issue_gnt: dma_gnt=%b cpu_gnt=%b expected 0 0", dma_gnt, cpu_gnt);
        end
        next_cycle();
        RST = 0;
        dma_req = 0;
        mem_rdata = 32'h55AA55AA;
        @(negedge CLK);
        checks++;
        if (cpu_rvalid !== 1'b0 || busy !== 1'b0 || mem_en !== 1'b0 || rdata !== 32'h0 ||
            mem_addr !== 32'h0 || dma_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL rst_issue_after: cpu_rvalid=%b busy=%b mem_en=%b rdata=%h mem_addr=%h expected all 0",
                     cpu_rvalid, busy, mem_en, rdata, mem_addr);
        end
        next_cycle();
        @(negedge CLK);
        checks++;
        if (cpu_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL rst_issue_late_rvalid: cpu_rvalid=%b expected 0", cpu_rvalid);
        end
        next_cycle();
    endtask

    task automatic test_withdraw();
        logic saw_gnt;
        logic saw_mem;
        pulse_reset();
        cpu_req = 1; cpu_addr = 32'h40;
        @(negedge CLK);
        next_cycle();
        cpu_req = 0;
        dma_req = 1; dma_we = 1; dma_addr = 32'h80; dma_wdata = 32'hA5A5A5A5;
        saw_gnt = 0;
        saw_mem = 0;
        @(negedge CLK);
        saw_gnt = saw_gnt | dma_gnt;
        next_cycle();
        dma_req = 0;
        @(negedge CLK);
        saw_gnt = saw_gnt | dma_gnt;
        next_cycle();
        @(negedge CLK);
        saw_mem = mem_en | busy;
        checks++;
        if (saw_gnt !== 1'b0 || saw_mem !== 1'b0) begin
            failures++;
            $display("FAIL withdraw: dma_gnt_seen=%b access_seen=%b expected 0 0", saw_gnt, saw_mem);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        pulse_reset();
        cpu_req = 1; cpu_addr = 32'h100;
        @(negedge CLK);
        next_cycle();
        cpu_addr = 32'h300;    // reasserted in the cycle right after the grant
        @(negedge CLK);
        checks++;
        if (cpu_gnt !== 1'b0 || mem_en !== 1'b1) begin
            failures++;
            $display("FAIL b2b_issue: cpu_gnt=%b mem_en=%b expected 0 1", cpu_gnt, mem_en);
        end
        next_cycle();
        mem_rdata = 32'h0BADF00D;
        @(negedge CLK);
        checks++;
        if (cpu_gnt !== 1'b1 || cpu_rvalid !== 1'b1 || rdata !== 32'h0BADF00D) begin
            failures++;
            $display("FAIL b2b_resp_gnt: cpu_gnt=%b cpu_rvalid=%b rdata=%h expected 1 1 0badf00d",
                     cpu_gnt, cpu_rvalid, rdata);
        end
        next_cycle();
        cpu_req = 0;
        @(negedge CLK);
        checks++;
        if (mem_en !== 1'b1 || mem_addr !== 32'h300) begin
            failures++;
            $display("FAIL b2b_second_issue: mem_en=%b mem_addr=%h expected 1 00000300", mem_en, mem_addr);
        end
        next_cycle();
        next_cycle();
    endtask

    // Reference: a grant may occur only if there was none the previous cycle;
    // the granted access appears on memory one cycle later and a read returns
    // one cycle after that.
    task automatic test_random();
        acc_t h1, h2, nw;
        logic m_last;    // 1 = DMA granted most recently
        logic pcg, pdg, ecg, edg;
        logic [6:0]  exp_ctl, got_ctl;
        logic [31:0] exp_rd;
        pulse_reset();
        h1 = '0; h2 = '0; m_last = 1'b1; pcg = 0; pdg = 0;
        for (int i = 0; i < 600; i++) begin
            if (pcg || !cpu_req) begin
                cpu_req = ($urandom_range(0, 99) < 45);
                cpu_we = 1'($urandom_range(0, 1)); cpu_addr = $urandom;
                cpu_wdata = $urandom; cpu_size = 2'($urandom_range(0, 2));
            end else if ($urandom_range(0, 15) == 0) begin
                cpu_req = 0;
            end
            if (pdg || !dma_req) begin
                dma_req = ($urandom_range(0, 99) < 45);
                dma_we = 1'($urandom_range(0, 1)); dma_addr = $urandom;
                dma_wdata = $urandom; dma_size = 2'($urandom_range(0, 2));
            end else if ($urandom_range(0, 15) == 0) begin
                dma_req = 0;
            end
            mem_rdata = $urandom;
            @(negedge CLK);
            ecg = 0; edg = 0;
            if (!h1.v) begin
                if (cpu_req && dma_req) begin
`ifdef OTTER_MEM_ARB_RR_EN
                    ecg = m_last; edg = !m_last;
`else
                    ecg = 1;
`endif
                end else begin
                    ecg = cpu_req; edg = dma_req;
                end
            end
            exp_ctl = {ecg, edg, h1.v, h1.v & h1.we,
                       h2.v & !h2.we & !h2.who, h2.v & !h2.we & h2.who, h1.v | h2.v};
            got_ctl = {cpu_gnt, dma_gnt, mem_en, mem_we, cpu_rvalid, dma_rvalid, busy};
            exp_rd = (h2.v && !h2.we) ? mem_rdata : 32'h0;
            checks++;
            if (got_ctl !== exp_ctl || rdata !== exp_rd) begin
                failures++;
                $display("FAIL random_ctl cyc=%0d: gnt/gnt/en/we/rv/rv/busy=%b rdata=%h expected %b rdata=%h",
                         i, got_ctl, rdata, exp_ctl, exp_rd);
            end
            if (h1.v) begin
                checks++;
                if (mem_addr !== h1.addr || mem_wdata !== h1.wdata || mem_size !== h1.size) begin
                    failures++;
                    $display("FAIL random_fields cyc=%0d: addr=%h wdata=%h size=%b expected %h %h %b",
                             i, mem_addr, mem_wdata, mem_size, h1.addr, h1.wdata, h1.size);
                end
            end
            nw.v     = ecg | edg;
            nw.who   = edg;
            nw.we    = edg ? dma_we : cpu_we;
            nw.addr  = edg ? dma_addr : cpu_addr;
            nw.wdata = edg ? dma_wdata : cpu_wdata;
            nw.size  = edg ? dma_size : cpu_size;
            h2 = h1;
            h1 = nw;
            if (nw.v) m_last = edg;
            pcg = ecg; pdg = edg;
            next_cycle();
        end
        clr_inputs();
        next_cycle();
        next_cycle();
    endtask

    initial begin
        clr_inputs();
        RST = 1;
        next_cycle();
        test_reset();
        test_cpu_read();
        test_dma_write();
        test_contention();
        test_reset_in_issue();
        test_withdraw();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
